// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 UART receiver, LSB first, mid-bit sampling off a synchronised line; holds last good byte.
// Latency: SYNC_STAGES + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles from start-bit pin edge to o_RX_DV.
// Backpressure: none; the line cannot be stalled, so o_RX_DV / o_Frame_Err are one-cycle strobes.
// Optional: define UART_RX_PARITY_EN to add an even-parity bit between the data bits and the stop bit.
module uart_rx_byte #(
    parameter int CLKS_PER_BIT = 217,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic       i_RX_Serial,
    output logic       o_RX_DV,
    output logic [7:0] o_RX_Byte,
    output logic       o_Frame_Err,
    output logic       o_Busy
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_STOP   = 3'd3,
        S_BREAK  = 3'd4
`ifdef UART_RX_PARITY_EN
        , S_PARITY = 3'd5
`endif
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [2:0]             idx_q, idx_d;
    logic [7:0]             shift_q, shift_d;
    logic [7:0]             byte_q, byte_d;
    logic                   dv_q, dv_d;
    logic                   err_q, err_d;
    logic                   rx_s;
    logic                   half_hit;
    logic                   bit_hit;
    logic                   frame_ok;

    assign sync_d   = {sync_q[SYNC_STAGES-2:0], i_RX_Serial};
    assign rx_s     = sync_q[SYNC_STAGES-1];
    assign half_hit = (cnt_q == HALF_LAST);
    assign bit_hit  = (cnt_q == BIT_LAST);

`ifdef UART_RX_PARITY_EN
    logic par_ok_q, par_ok_d;
    assign frame_ok = par_ok_q;
`else
    assign frame_ok = 1'b1;
`endif

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q  <= S_IDLE;
            sync_q   <= '1;
            cnt_q    <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            byte_q   <= '0;
            dv_q     <= 1'b0;
            err_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_ok_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            sync_q   <= sync_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            byte_q   <= byte_d;
            dv_q     <= dv_d;
            err_q    <= err_d;
`ifdef UART_RX_PARITY_EN
            par_ok_q <= par_ok_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (!rx_s) state_d = S_START;
            // A line that is high again at mid start bit was a glitch.
            S_START: if (half_hit) state_d = rx_s ? S_IDLE : S_DATA;
`ifdef UART_RX_PARITY_EN
            S_DATA:   if (bit_hit && idx_q == 3'd7) state_d = S_PARITY;
            S_PARITY: if (bit_hit) state_d = S_STOP;
`else
            S_DATA:  if (bit_hit && idx_q == 3'd7) state_d = S_STOP;
`endif
            S_STOP:  if (bit_hit) state_d = rx_s ? S_IDLE : S_BREAK;
            S_BREAK: if (rx_s) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        byte_d  = byte_q;
        dv_d    = 1'b0;
        err_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_ok_d = par_ok_q;
`endif
        case (state_q)
            S_START: begin
                cnt_d = half_hit ? '0 : cnt_q + CW'(1);
                idx_d = '0;
            end
            S_DATA: begin
                cnt_d = bit_hit ? '0 : cnt_q + CW'(1);
                if (bit_hit) begin
                    shift_d[idx_q] = rx_s;
                    idx_d          = idx_q + 3'd1;
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                cnt_d = bit_hit ? '0 : cnt_q + CW'(1);
                if (bit_hit) par_ok_d = (rx_s == ^shift_q);
            end
`endif
            S_STOP: begin
                cnt_d = bit_hit ? '0 : cnt_q + CW'(1);
                if (bit_hit) begin
                    if (rx_s && frame_ok) begin
                        byte_d = shift_q;
                        dv_d   = 1'b1;
                    end else begin
                        err_d  = 1'b1;
                    end
                end
            end
            default: cnt_d = '0;
        endcase
    end

    always_comb begin
        o_Busy = (state_q != S_IDLE);
    end

    assign o_RX_DV     = dv_q;
    assign o_RX_Byte   = byte_q;
    assign o_Frame_Err = err_q;
endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed bench for uart_rx_byte: frame-level model predicts strobe cycles and held byte from pin activity.
module tb_uart_rx_byte;
    localparam int C    = 8;
    localparam int SYNC = 2;
`ifdef UART_RX_PARITY_EN
    localparam int PBITS = 1;
    localparam int A5_LAT = 87;
`else
    localparam int PBITS = 0;
    localparam int A5_LAT = 79;
`endif
    // Pin edge -> synchroniser -> mid start bit -> 8 data (+parity) + stop bit periods -> registered strobe.
    localparam int LAT = SYNC + C / 2 + (9 + PBITS) * C + 1;

    typedef struct {
        int         cyc;
        bit         err;
        logic [7:0] val;
    } ev_t;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx    = 1'b1;
    logic       rx_dv;
    logic [7:0] rx_byte;
    logic       frame_err;
    logic       busy;

    int         cyc         = 0;
    int         n_checks    = 0;
    int         n_err       = 0;
    int         dv_count    = 0;
    int         err_count   = 0;
    int         last_dv_cyc = -1;
    logic [7:0] model_byte  = 8'h00;
    ev_t        exp_q[$];

    uart_rx_byte #(.CLKS_PER_BIT(C), .SYNC_STAGES(SYNC)) dut (
        .i_Clk       (clk),
        .i_Rst_L     (rst_n),
        .i_RX_Serial (rx),
        .o_RX_DV     (rx_dv),
        .o_RX_Byte   (rx_byte),
        .o_Frame_Err (frame_err),
        .o_Busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    // Called at a negedge; drives one whole frame and records the outcome it must produce.
    task automatic send_frame(input logic [7:0] b, input logic stop_v, input logic par_bad);
        ev_t ev;
        ev.cyc = cyc + LAT;
        ev.err = !stop_v || par_bad;
        ev.val = b;
        exp_q.push_back(ev);
        rx = 1'b0;
        repeat (C) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (C) @(negedge clk);
        end
`ifdef UART_RX_PARITY_EN
        rx = (^b) ^ par_bad;
        repeat (C) @(negedge clk);
`endif
        rx = stop_v;
        repeat (C) @(negedge clk);
    endtask

    initial begin
        bit   exp_dv;
        bit   exp_err;
        forever begin
            @(posedge clk);
            #2;
            exp_dv  = 1'b0;
            exp_err = 1'b0;
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                if (exp_q[0].err) begin
                    exp_err = 1'b1;
                end else begin
                    exp_dv     = 1'b1;
                    model_byte = exp_q[0].val;
                end
                void'(exp_q.pop_front());
            end
            chk("rx_dv", int'(rx_dv), int'(exp_dv));
            chk("frame_err", int'(frame_err), int'(exp_err));
            chk("rx_byte", int'(rx_byte), int'(model_byte));
            if (rx_dv === 1'b1) begin
                dv_count++;
                last_dv_cyc = cyc;
            end
            if (frame_err === 1'b1) err_count++;
        end
    end

    initial begin
        int         t0;
        int         n0;
        int         e0;
        logic [7:0] ab;

        rst_n = 1'b0;
        rx    = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        chk("idle_byte", int'(rx_byte), 0);
        chk("idle_busy", int'(busy), 0);
        chk("idle_dv_count", dv_count, 0);

        t0 = cyc;
        send_frame(8'hA5, 1'b1, 1'b0);
        repeat (C) @(negedge clk);
        chk("a5_latency", last_dv_cyc - t0, A5_LAT);
        chk("a5_dv_count", dv_count, 1);
        chk("a5_byte", int'(rx_byte), 8'hA5);
        repeat (50) @(negedge clk);
        chk("a5_held", int'(rx_byte), 8'hA5);

        n0 = dv_count;
        send_frame(8'h3C, 1'b1, 1'b0);
        send_frame(8'hF0, 1'b1, 1'b0);
        repeat (20) @(negedge clk);
        chk("b2b_dv_count", dv_count - n0, 2);
        chk("b2b_byte", int'(rx_byte), 8'hF0);

        n0 = dv_count;
        e0 = err_count;
        rx = 1'b0;
        repeat (2) @(negedge clk);
        rx = 1'b1;
        repeat (2) @(negedge clk);
        chk("glitch_busy_on", int'(busy), 1);
        repeat (6) @(negedge clk);
        chk("glitch_busy_off", int'(busy), 0);
        repeat (20) @(negedge clk);
        chk("glitch_no_dv", dv_count - n0, 0);
        chk("glitch_no_err", err_count - e0, 0);

        e0 = err_count;
        send_frame(8'h55, 1'b0, 1'b0);
        repeat (100) @(negedge clk);
        chk("break_busy", int'(busy), 1);
        repeat (100) @(negedge clk);
        rx = 1'b1;
        repeat (10) @(negedge clk);
        chk("break_busy_off", int'(busy), 0);
        chk("break_err_count", err_count - e0, 1);
        chk("break_byte_held", int'(rx_byte), 8'hF0);
        send_frame(8'h12, 1'b1, 1'b0);
        repeat (10) @(negedge clk);
        chk("after_break_byte", int'(rx_byte), 8'h12);

        ab = 8'h77;
        rx = 1'b0;
        repeat (C) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = ab[i];
            repeat (C) @(negedge clk);
        end
        rx = ab[4];
        repeat (C / 2) @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        model_byte = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset_byte", int'(rx_byte), 0);
        chk("reset_busy", int'(busy), 0);
        rst_n = 1'b1;
        rx    = 1'b1;
        repeat (20) @(negedge clk);
        chk("post_reset_byte", int'(rx_byte), 0);
        send_frame(8'h81, 1'b1, 1'b0);
        repeat (10) @(negedge clk);
        chk("rx81_byte", int'(rx_byte), 8'h81);

`ifdef UART_RX_PARITY_EN
        e0 = err_count;
        send_frame(8'h81, 1'b1, 1'b1);
        repeat (10) @(negedge clk);
        chk("parity_err_count", err_count - e0, 1);
        chk("parity_byte_held", int'(rx_byte), 8'h81);
`endif

        repeat (20) @(negedge clk);
        chk("pending_events", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/uart_rx_byte.md
Name: uart_rx_byte

Overview:
- Serial UART receiver, 8N1, LSB first, oversampled on the 25 MHz board clock.
- Produces the received byte `o_RX_Byte` that top level drives into both 7-segment digit decoders: upper nibble to Segment1, lower nibble to Segment2.
- Also provides a one-cycle valid strobe, which downstream consumers use to write game commands.
- Holds the last good byte until the next valid frame arrives, so the display stays stable.

Parameters:
- CLKS_PER_BIT, 217, i_Clk cycles per bit (25 MHz / 115200). Legal range ≥ 4.
- SYNC_STAGES, 2, metastability flops on i_RX_Serial. Legal range ≥ 2.

Ports:
- i_Clk  in  1  system clock; all logic on rising edge.
- i_Rst_L  in  1  asynchronous active-low reset.
- i_RX_Serial  in  1  asynchronous serial line, idle high.
- o_RX_DV  out  1  one-cycle strobe: new byte valid this cycle.
- o_RX_Byte  out  8  last correctly received byte; held between frames.
- o_Frame_Err  out  1  one-cycle strobe: stop bit sampled low.
- o_Busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (i_Rst_L low, asynchronous, any time, including mid-frame):
  - state = IDLE; bit counter = 0; cycle counter = 0.
  - Synchronizer flops = 1.
  - o_RX_DV = 0, o_RX_Byte = 8'h00, o_Frame_Err = 0, o_Busy = 0.
  - Partial frame is discarded. After release, the receiver waits for a fresh falling edge.
- Synchronizer and counter:
  - The synchronized line `rx_s` is the SYNC_STAGES-flop output. All decisions use `rx_s`.
  - Cycle counter width is $clog2(CLKS_PER_BIT). It counts 0..limit, then clears.
- IDLE:
  - If rx_s = 0, go to START and clear the counter. Otherwise stay.
- START:
  - Count to (CLKS_PER_BIT/2 − 1), integer division, i.e. mid start bit. Then sample rx_s.
  - rx_s = 0: go to DATA, clear bit index.
  - rx_s = 1: glitch/false start. Return to IDLE with no strobe.
- DATA:
  - Count to CLKS_PER_BIT − 1, then sample rx_s into shift bit[index], LSB first.
  - After index 7, go to STOP (or PARITY, see Optional Feature).
- STOP:
  - Count to CLKS_PER_BIT − 1, then sample rx_s.
  - rx_s = 1: load o_RX_Byte with the shift register. Pulse o_RX_DV for exactly one cycle (the cycle after the sample). Go to IDLE.
  - rx_s = 0: pulse o_Frame_Err for one cycle. o_RX_Byte is unchanged. Go to BREAK.
- BREAK:
  - Stay until rx_s = 1, then go to IDLE. A held-low line produces exactly one o_Frame_Err, not repeated frames.
- Latency:
  - Stop sample occurs CLKS_PER_BIT/2 + 9·CLKS_PER_BIT cycles after rx_s first reads 0. With defaults: 108 + 1953 = 2061 cycles.
  - o_RX_DV rises one cycle later.
  - Total from pin edge: +SYNC_STAGES cycles.
- Back-to-back frames:
  - The receiver is back in IDLE half a bit before the stop bit ends. A start bit immediately following the stop bit must be accepted with no lost byte.
- Output exclusivity:
  - o_RX_DV and o_Frame_Err are never high in the same cycle.
  - Neither is high for more than one consecutive cycle.
- o_Busy:
  - Combinational from state: 1 in START, DATA, PARITY, STOP and BREAK.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP, one bit period long, sampled at mid-bit.
  - Even parity is checked over the 8 data bits.
  - On mismatch, the frame still runs through STOP. Then o_Frame_Err pulses instead of o_RX_DV, and o_RX_Byte is unchanged.
  - Stop-sample latency grows by CLKS_PER_BIT.
- Undefined:
  - No PARITY state, no parity logic; 8N1 exactly as above.

Test Plan (CLKS_PER_BIT = 8, SYNC_STAGES = 2):
- Reset, then line idle high for 100 cycles -> o_RX_Byte = 00, o_RX_DV never asserted, o_Busy = 0.
- Send 0xA5 (8N1) -> single o_RX_DV pulse exactly 2 + 4 + 72 + 1 cycles after the pin falling edge; o_RX_Byte = A5 and held afterwards.
- Send 0x3C then 0xF0 back-to-back, no idle gap -> two o_RX_DV pulses; o_RX_Byte = 3C, then F0.
- 2-cycle low glitch on idle line -> o_Busy high briefly, return to IDLE; no o_RX_DV, no o_Frame_Err.
- Frame 0x55 with stop bit forced low, then line held low for 200 cycles, then released -> exactly one o_Frame_Err pulse; o_RX_Byte keeps previous value; next valid 0x12 frame is received correctly.
- Assert i_Rst_L low during DATA bit 4 of 0x77, release, send 0x81 -> no strobe for the aborted frame; o_RX_Byte = 00, then 81. With UART_RX_PARITY_EN, sending 0x81 with a wrong parity bit -> o_Frame_Err pulse, o_RX_Byte unchanged.
